// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the hazard unit: forwarding select encoding,
// multiply sequencer state type, and the forwarding priority helper.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    RDS_RF = 2'd0,
    RDS_M  = 2'd1,
    RDS_W  = 2'd2
  } register_data_sel;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } hz_state_t;

  // Down-counter width; covers MUL_LAT up to 15.
  localparam int unsigned CNT_W = 4;

  // M beats W; x0 is never forwarded.
  function automatic register_data_sel fwd_sel(
    input logic       we_m,
    input logic [4:0] rd_m,
    input logic       we_w,
    input logic [4:0] rd_w,
    input logic [4:0] rs
  );
    if (we_m && (rd_m != '0) && (rd_m == rs))
      return RDS_M;
    else if (we_w && (rd_w != '0) && (rd_w == rs))
      return RDS_W;
    else
      return RDS_RF;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle.
//   master : pipeline side, drives register indices / control, receives stall, flush, forwarding selects
//   slave  : hazard unit side
interface hazard_unit_if;
  import hazard_unit_pkg::*;

  logic [4:0]       rs1_d, rs2_d;
  logic [4:0]       rs1_e, rs2_e, rd_e;
  logic [4:0]       rd_m, rd_w;
  logic             reg_write_m, reg_write_w;
  logic             mem_read_e;
  logic             mul_start_e;
  logic             branch_hit;
  logic             stall_f, stall_d, stall_e;
  logic             flush_f, flush_d, flush_e;
  register_data_sel r1_e_sel, r2_e_sel;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
           reg_write_m, reg_write_w, mem_read_e, mul_start_e, branch_hit,
    input  stall_f, stall_d, stall_e, flush_f, flush_d, flush_e,
           r1_e_sel, r2_e_sel
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
           reg_write_m, reg_write_w, mem_read_e, mul_start_e, branch_hit,
    output stall_f, stall_d, stall_e, flush_f, flush_d, flush_e,
           r1_e_sel, r2_e_sel
  );
endinterface

// File: rtl/hz_mul_seq.sv
// Multiply occupancy sequencer: holds E for MUL_LAT cycles after a start.
//   clk, rst : clock, synchronous active-high reset
//   start    : qualified multiply start (already excludes branch redirect)
//   busy     : sequencer is in BUSY (registered state)
//   stall    : multiply stall for this cycle (start cycle plus BUSY cycles)
module hz_mul_seq
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic stall
);

  hz_state_t          state;
  logic [CNT_W-1:0]   cnt;

  // The start cycle itself stalls combinationally, so BUSY only has to
  // cover the remaining MUL_LAT-1 cycles: load MUL_LAT-2 and leave at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_BUSY;
            cnt   <= CNT_W'(MUL_LAT - 2);
          end
        end
        ST_BUSY: begin
          if (cnt == '0)
            state <= ST_IDLE;
          else
            cnt <= cnt - CNT_W'(1);
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy  = (state == ST_BUSY);
  assign stall = busy | start;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: multiply occupancy stalls, load-use interlock,
// branch flush, E-stage operand forwarding and a stall cycle counter.
//   clk, rst     : clock, synchronous active-high reset
//   hif (slave)  : register indices / control in; stall, flush, forwarding selects out
//   stall_cycles : number of cycles with stall_d asserted (wrapping)
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  hazard_unit_if.slave    hif,
  output logic [XLEN-1:0] stall_cycles
);

  logic mul_busy;
  logic mul_stall;
  logic mul_go;
  logic load_use;

  // A redirecting branch kills the multiply before it can occupy E.
  assign mul_go = hif.mul_start_e & ~hif.branch_hit;

  hz_mul_seq #(
    .MUL_LAT (MUL_LAT)
  ) u_mul_seq (
    .clk   (clk),
    .rst   (rst),
    .start (mul_go),
    .busy  (mul_busy),
    .stall (mul_stall)
  );

  assign load_use = hif.mem_read_e && (hif.rd_e != '0) &&
                    ((hif.rd_e == hif.rs1_d) || (hif.rd_e == hif.rs2_d));

  // Priority: reset, multiply in progress, branch, multiply start, load-use.
  // A load-use coinciding with a multiply start is covered by the full stall.
  always_comb begin
    hif.stall_f  = 1'b0;
    hif.stall_d  = 1'b0;
    hif.stall_e  = 1'b0;
    hif.flush_f  = 1'b0;
    hif.flush_d  = 1'b0;
    hif.flush_e  = 1'b0;
    hif.r1_e_sel = RDS_RF;
    hif.r2_e_sel = RDS_RF;
    if (rst) begin
      hif.flush_f = 1'b1;
      hif.flush_d = 1'b1;
      hif.flush_e = 1'b1;
    end else begin
      hif.r1_e_sel = fwd_sel(hif.reg_write_m, hif.rd_m, hif.reg_write_w, hif.rd_w, hif.rs1_e);
      hif.r2_e_sel = fwd_sel(hif.reg_write_m, hif.rd_m, hif.reg_write_w, hif.rd_w, hif.rs2_e);
      if (mul_busy) begin
        hif.stall_f = 1'b1;
        hif.stall_d = 1'b1;
        hif.stall_e = 1'b1;
      end else if (hif.branch_hit) begin
        hif.flush_f = 1'b1;
        hif.flush_d = 1'b1;
      end else if (mul_stall) begin
        hif.stall_f = 1'b1;
        hif.stall_d = 1'b1;
        hif.stall_e = 1'b1;
      end else if (load_use) begin
        hif.stall_f = 1'b1;
        hif.stall_d = 1'b1;
        hif.flush_e = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= '0;
    else if (hif.stall_d)
      stall_cycles <= stall_cycles + XLEN'(1);
  end

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] stall_cycles;
  logic [2:0]  stall_cycles2;

  hazard_unit_if hif ();
  hazard_unit_if w2 ();

  hazard_unit #(
    .MUL_LAT (4),
    .XLEN    (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hif          (hif.slave),
    .stall_cycles (stall_cycles)
  );

  // Small counter instance to exercise the wrap from all-ones.
  hazard_unit #(
    .MUL_LAT (7),
    .XLEN    (3)
  ) dut_wrap (
    .clk          (clk),
    .rst          (rst),
    .hif          (w2.slave),
    .stall_cycles (stall_cycles2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_sc   = '0;

  typedef struct {
    string            name;
    logic             mem_read_e;
    logic [4:0]       rd_e, rs1_d, rs2_d;
    logic             branch_hit;
    logic [4:0]       rs1_e, rs2_e, rd_m, rd_w;
    logic             we_m, we_w;
    logic [2:0]       e_stall;   // {f,d,e}
    logic [2:0]       e_flush;   // {f,d,e}
    register_data_sel e_r1, e_r2;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_in();
    hif.rs1_d = '0; hif.rs2_d = '0; hif.rs1_e = '0; hif.rs2_e = '0; hif.rd_e = '0;
    hif.rd_m = '0; hif.rd_w = '0; hif.reg_write_m = 1'b0; hif.reg_write_w = 1'b0;
    hif.mem_read_e = 1'b0; hif.mul_start_e = 1'b0; hif.branch_hit = 1'b0;
  endtask

  // Check combinational outputs for the current cycle, advance one edge,
  // then check the stall counter against the bench's running expectation.
  task automatic cyc(input string nm, input logic [2:0] es, input logic [2:0] ef,
                     input register_data_sel e1, input register_data_sel e2);
    logic was_rst;
    #1;
    chk({nm, ".stall"}, 32'({hif.stall_f, hif.stall_d, hif.stall_e}), 32'(es));
    chk({nm, ".flush"}, 32'({hif.flush_f, hif.flush_d, hif.flush_e}), 32'(ef));
    chk({nm, ".sel"},   32'({hif.r1_e_sel, hif.r2_e_sel}), 32'({e1, e2}));
    was_rst = rst;
    @(posedge clk);
    #1;
    if (was_rst) exp_sc = '0;
    else if (es[1]) exp_sc = exp_sc + 1;
    chk({nm, ".stall_cycles"}, stall_cycles, exp_sc);
  endtask

  logic [31:0] sc_before;

  initial begin
    //          name       mr rd_e rs1d rs2d br rs1e rs2e rd_m rd_w wm ww stall   flush   r1      r2
    vecs[0]  = '{"idle",    0, 0,   0,   0,   0, 0,   0,   0,   0,   0, 0, 3'b000, 3'b000, RDS_RF, RDS_RF};
    vecs[1]  = '{"lu_rs2",  1, 5,   1,   5,   0, 0,   0,   0,   0,   0, 0, 3'b110, 3'b001, RDS_RF, RDS_RF};
    vecs[2]  = '{"lu_x0",   1, 0,   0,   0,   0, 0,   0,   0,   0,   0, 0, 3'b000, 3'b000, RDS_RF, RDS_RF};
    vecs[3]  = '{"lu_rs1",  1, 9,   9,   2,   0, 0,   0,   0,   0,   0, 0, 3'b110, 3'b001, RDS_RF, RDS_RF};
    vecs[4]  = '{"no_load", 0, 5,   1,   5,   0, 0,   0,   0,   0,   0, 0, 3'b000, 3'b000, RDS_RF, RDS_RF};
    vecs[5]  = '{"br_lu",   1, 5,   1,   5,   1, 0,   0,   0,   0,   0, 0, 3'b000, 3'b110, RDS_RF, RDS_RF};
    vecs[6]  = '{"br_only", 0, 0,   0,   0,   1, 0,   0,   0,   0,   0, 0, 3'b000, 3'b110, RDS_RF, RDS_RF};
    vecs[7]  = '{"fwd_m",   0, 0,   0,   0,   0, 7,   0,   7,   7,   1, 1, 3'b000, 3'b000, RDS_M,  RDS_RF};
    vecs[8]  = '{"fwd_w",   0, 0,   0,   0,   0, 7,   0,   7,   7,   0, 1, 3'b000, 3'b000, RDS_W,  RDS_RF};
    vecs[9]  = '{"fwd_x0",  0, 0,   0,   0,   0, 7,   0,   0,   0,   1, 1, 3'b000, 3'b000, RDS_RF, RDS_RF};
    vecs[10] = '{"fwd_mix", 0, 0,   0,   0,   0, 3,   12,  3,   12,  1, 1, 3'b000, 3'b000, RDS_M,  RDS_W};
    vecs[11] = '{"fwd_off", 0, 0,   0,   0,   0, 0,   4,   0,   4,   1, 0, 3'b000, 3'b000, RDS_RF, RDS_RF};

    clear_in();
    w2.rs1_d = '0; w2.rs2_d = '0; w2.rs1_e = '0; w2.rs2_e = '0; w2.rd_e = '0;
    w2.rd_m = '0; w2.rd_w = '0; w2.reg_write_m = 1'b0; w2.reg_write_w = 1'b0;
    w2.mem_read_e = 1'b0; w2.mul_start_e = 1'b0; w2.branch_hit = 1'b0;
    rst = 1'b1;
    hif.rs1_e = 5'd7; hif.rd_m = 5'd7; hif.reg_write_m = 1'b1;
    cyc("reset", 3'b000, 3'b111, RDS_RF, RDS_RF);
    rst = 1'b0;
    clear_in();

    for (int i = 0; i < 12; i++) begin
      hif.mem_read_e  = vecs[i].mem_read_e;
      hif.rd_e        = vecs[i].rd_e;
      hif.rs1_d       = vecs[i].rs1_d;
      hif.rs2_d       = vecs[i].rs2_d;
      hif.branch_hit  = vecs[i].branch_hit;
      hif.rs1_e       = vecs[i].rs1_e;
      hif.rs2_e       = vecs[i].rs2_e;
      hif.rd_m        = vecs[i].rd_m;
      hif.rd_w        = vecs[i].rd_w;
      hif.reg_write_m = vecs[i].we_m;
      hif.reg_write_w = vecs[i].we_w;
      cyc(vecs[i].name, vecs[i].e_stall, vecs[i].e_flush, vecs[i].e_r1, vecs[i].e_r2);
    end
    clear_in();

    // Multiply: 4 stall cycles; restart/branch/load-use during BUSY ignored.
    sc_before = stall_cycles;
    hif.mul_start_e = 1'b1;
    cyc("mul0", 3'b111, 3'b000, RDS_RF, RDS_RF);
    hif.mul_start_e = 1'b0;
    cyc("mul1", 3'b111, 3'b000, RDS_RF, RDS_RF);
    hif.mul_start_e = 1'b1; hif.branch_hit = 1'b1;
    hif.mem_read_e = 1'b1; hif.rd_e = 5'd5; hif.rs2_d = 5'd5;
    cyc("mul2", 3'b111, 3'b000, RDS_RF, RDS_RF);
    clear_in();
    cyc("mul3", 3'b111, 3'b000, RDS_RF, RDS_RF);
    cyc("mul4", 3'b000, 3'b000, RDS_RF, RDS_RF);
    cyc("mul5", 3'b000, 3'b000, RDS_RF, RDS_RF);
    chk("mul_sc_delta", stall_cycles - sc_before, 32'd4);

    // Multiply start killed by a simultaneous branch.
    hif.mul_start_e = 1'b1; hif.branch_hit = 1'b1;
    cyc("mulbr0", 3'b000, 3'b110, RDS_RF, RDS_RF);
    clear_in();
    cyc("mulbr1", 3'b000, 3'b000, RDS_RF, RDS_RF);

    // Reset in the 2nd BUSY cycle aborts the sequence.
    hif.mul_start_e = 1'b1;
    cyc("rb0", 3'b111, 3'b000, RDS_RF, RDS_RF);
    hif.mul_start_e = 1'b0;
    cyc("rb1", 3'b111, 3'b000, RDS_RF, RDS_RF);
    rst = 1'b1;
    cyc("rb_rst", 3'b000, 3'b111, RDS_RF, RDS_RF);
    rst = 1'b0;
    chk("rb_sc_zero", stall_cycles, 32'd0);
    cyc("rb_after0", 3'b000, 3'b000, RDS_RF, RDS_RF);
    cyc("rb_after1", 3'b000, 3'b000, RDS_RF, RDS_RF);

    // Multiply start during reset is discarded.
    rst = 1'b1; hif.mul_start_e = 1'b1;
    cyc("mr_rst", 3'b000, 3'b111, RDS_RF, RDS_RF);
    rst = 1'b0; hif.mul_start_e = 1'b0;
    cyc("mr_after", 3'b000, 3'b000, RDS_RF, RDS_RF);

    // Counter wrap on the 3-bit instance: 7 multiply stalls reach all-ones.
    chk("wrap_start", 32'(stall_cycles2), 32'd0);
    w2.mul_start_e = 1'b1;
    @(posedge clk); #1;
    w2.mul_start_e = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    chk("wrap_ones", 32'(stall_cycles2), 32'd7);
    chk("wrap_idle", 32'(w2.stall_d), 32'd0);
    w2.mem_read_e = 1'b1; w2.rd_e = 5'd3; w2.rs1_d = 5'd3;
    #1;
    chk("wrap_lu", 32'(w2.stall_d), 32'd1);
    @(posedge clk); #1;
    w2.mem_read_e = 1'b0; w2.rd_e = '0; w2.rs1_d = '0;
    chk("wrap_zero", 32'(stall_cycles2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter MUL_LAT, default 4: multiplier occupancy of the E stage in cycles; legal range 2..15.
REQ-002 Parameter XLEN, default 32: width of the performance counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 rs1_d, rs2_d  input  5 each  source register indices of the instruction in D.
REQ-006 rs1_e, rs2_e, rd_e  input  5 each  source and destination indices of the instruction in E.
REQ-007 rd_m, rd_w  input  5 each  destination indices of the instructions in M and W.
REQ-008 reg_write_m, reg_write_w  input  1 each  the M or W instruction writes rd.
REQ-009 mem_read_e  input  1  the E instruction is a load.
REQ-010 mul_start_e  input  1  a multiply has entered E this cycle.
REQ-011 branch_hit  input  1  the E instruction redirects the PC (taken branch or jump).
REQ-012 stall_f, stall_d, stall_e  output  1 each  hold the F, D and E pipeline registers.
REQ-013 flush_f, flush_d, flush_e  output  1 each  clear the F, D and E pipeline registers at the next edge.
REQ-014 r1_e_sel, r2_e_sel  output  register_data_sel  operand forwarding select for E.
REQ-015 stall_cycles  output  XLEN  count of cycles in which stall_d was high.

Function
REQ-016 The FSM has two states:
- IDLE: moves to BUSY when mul_start_e=1 and branch_hit=0.
- BUSY: holds a down-counter; returns to IDLE after the last stall cycle.
REQ-017 stall_f, stall_d and stall_e are all high for exactly MUL_LAT consecutive cycles, starting in the cycle mul_start_e is sampled in IDLE; flush_* is low throughout.
REQ-018 mul_start_e received in BUSY is ignored.
REQ-019 A load-use hazard exists in IDLE when:
- mem_read_e=1, rd_e!=0, and rd_e equals rs1_d or rs2_d;
- the unit then drives stall_f=1, stall_d=1, flush_e=1 for that single cycle (latency 0, combinational).
REQ-020 branch_hit=1 in IDLE drives flush_f=1 and flush_d=1 for that cycle, with no stall.
REQ-021 When branch_hit and a load-use hazard are both present, branch_hit wins and the load-use response is suppressed.
REQ-022 branch_hit and the load-use check are ignored in BUSY.
REQ-023 r1_e_sel is chosen as follows (combinational):
- RDS_M if reg_write_m=1, rd_m!=0 and rd_m==rs1_e;
- else RDS_W if reg_write_w=1, rd_w!=0 and rd_w==rs1_e;
- else RDS_RF.
REQ-024 r2_e_sel uses the same rule with rs2_e; M has priority over W.
REQ-025 stall_cycles increments by 1 on every edge where stall_d=1 and rst=0, and wraps from all-ones to 0.
REQ-026 When no rule fires, all stall_* and flush_* outputs are 0.

Reset
REQ-027 While rst=1:
- FSM is forced to IDLE and the down-counter to 0;
- stall_f/d/e=0 and flush_f/d/e=1;
- r1_e_sel and r2_e_sel=RDS_RF;
- stall_cycles clears to 0 at the edge.
REQ-028 Reset asserted during BUSY aborts the sequence; after the reset edge the unit is in IDLE with stalls deasserted.
REQ-029 mul_start_e sampled in the same cycle as rst=1 is discarded.

Structure
REQ-030 The enum register_data_sel (RDS_RF=0, RDS_M=1, RDS_W=2, 2 bits) and the FSM state typedef live in the shared defs package.
REQ-031 The MUL_LAT sequencer (FSM plus down-counter) is a sub-module named hz_mul_seq; forwarding and load-use logic stay in hazard_unit.

Verification
REQ-032 MUL_LAT=4, mul_start_e pulsed 1 cycle in IDLE:
- stall_f/d/e high for exactly 4 cycles, then low;
- stall_cycles advances by 4.
REQ-033 mem_read_e=1, rd_e=5, rs2_d=5:
- one cycle of stall_f=stall_d=flush_e=1;
- with rd_e=0, no response.
REQ-034 branch_hit=1 together with the load-use condition of REQ-033: flush_f=flush_d=1, stall_d=0, flush_e=0.
REQ-035 Forwarding select, with rs1_e=7:
- rd_m=rd_w=7, both writing: r1_e_sel=RDS_M;
- reg_write_m=0: RDS_W;
- rd_m=rd_w=0: RDS_RF.
REQ-036 rst asserted in the 2nd BUSY cycle with MUL_LAT=4:
- flush_f/d/e=1 and stall=0 during reset;
- IDLE with no stalls afterwards;
- stall_cycles=0.
REQ-037 Preload stall_cycles to all-ones, then stall one cycle: it wraps to 0.
